// File: rtl/dma_pkg.sv
// Shared types and constants for the OAM DMA engine.
// The MMU decodes DMA_REG_ADDR and produces the engine's start pulse.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STARTUP,
        XFER
    } dma_state_t;

    localparam logic [15:0] DMA_OAM_BASE   = 16'hFE00;
    localparam int          DMA_OAM_LEN    = 160;
    localparam int          DMA_T_PER_BYTE = 4;
    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;

    // Pages 0xE0-0xFF are echo RAM; fold them back onto WRAM at 0xC0-0xDF.
    function automatic logic [7:0] dma_eff_page(input logic [7:0] page);
        return (page >= 8'hE0) ? (page & 8'hDF) : page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA bus initiator: copies OAM_LEN bytes from a source page to OAM,
// one byte per M-cycle, after a one M-cycle startup delay.
module oam_dma
    import dma_pkg::*;
#(
    parameter logic [15:0] OAM_BASE   = DMA_OAM_BASE,
    parameter int          OAM_LEN    = DMA_OAM_LEN,
    parameter int          T_PER_BYTE = DMA_T_PER_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  src_page,
    output logic [15:0] bus_addr,
    output logic        bus_read,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        busy,
    output logic        cpu_block
);

    localparam logic [7:0] LP_LAST_IDX     = 8'(OAM_LEN - 1);
    localparam logic [7:0] LP_STARTUP_LAST = 8'(T_PER_BYTE - 1);

    dma_state_t  r_state, w_state_nxt;
    logic [7:0]  r_page,  w_page_nxt;
    logic [7:0]  r_idx,   w_idx_nxt;
    logic [1:0]  r_ph,    w_ph_nxt;
    logic [7:0]  r_cnt,   w_cnt_nxt;
    logic [15:0] r_addr,  w_addr_nxt;
    logic [7:0]  r_wdata, w_wdata_nxt;
    logic        r_read,  w_read_nxt;
    logic        r_write, w_write_nxt;
    logic        r_busy,  w_busy_nxt;
    logic        r_block, w_block_nxt;

    // Every output is computed one clock ahead and registered, so strobes and
    // status line up exactly with the state they describe.
    always_comb begin
        // NOTE: every next-value gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_idx_nxt   = r_idx;
        w_ph_nxt    = r_ph;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_block_nxt = r_block;

        unique case (r_state)
            IDLE: begin
            end
            STARTUP: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == LP_STARTUP_LAST) begin
                    w_state_nxt = XFER;
                    w_ph_nxt    = 2'd0;
                    w_read_nxt  = 1'b1;
                    w_addr_nxt  = {r_page, r_idx};
                    w_block_nxt = 1'b1;
                end
            end
            XFER: begin
                w_ph_nxt = r_ph + 2'd1;
                case (r_ph)
                    // Read data is valid now; capture it straight into the write register.
                    2'd1: begin
                        w_write_nxt = 1'b1;
                        w_addr_nxt  = OAM_BASE + {8'h00, r_idx};
                        w_wdata_nxt = bus_rdata;
                    end
                    2'd3: begin
                        if (r_idx == LP_LAST_IDX) begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                            w_block_nxt = 1'b0;
                        end else begin
                            w_idx_nxt  = r_idx + 8'd1;
                            w_read_nxt = 1'b1;
                            w_addr_nxt = {r_page, r_idx + 8'd1};
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: w_state_nxt = IDLE;
        endcase

        // A start in any state restarts the copy and drops any pending strobe.
        if (start) begin
            w_state_nxt = STARTUP;
            w_page_nxt  = dma_eff_page(src_page);
            w_idx_nxt   = 8'd0;
            w_ph_nxt    = 2'd0;
            w_cnt_nxt   = 8'd0;
            w_read_nxt  = 1'b0;
            w_write_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_block_nxt = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_page  <= 8'd0;
            r_idx   <= 8'd0;
            r_ph    <= 2'd0;
            r_cnt   <= 8'd0;
            r_addr  <= 16'd0;
            r_wdata <= 8'd0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_block <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_page  <= w_page_nxt;
            r_idx   <= w_idx_nxt;
            r_ph    <= w_ph_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_busy  <= w_busy_nxt;
            r_block <= w_block_nxt;
        end
    end

    assign bus_addr  = r_addr;
    assign bus_read  = r_read;
    assign bus_write = r_write;
    assign bus_wdata = r_wdata;
    assign busy      = r_busy;
    assign cpu_block = r_block;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a memory model answers reads, and every strobe
// is compared against a transfer schedule derived from the start history.
module tb_oam_dma;
    import dma_pkg::*;

    localparam int XFER_CLKS = 644;
    localparam int NO_BOUND  = 32'h3FFF_FFFF;

    typedef struct {
        int          t;
        logic [15:0] a;
        logic [7:0]  d;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  src_page;
    logic [15:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        busy;
    logic        cpu_block;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_on = 1'b0;
    int   mon_e;
    ev_t  mon_ev;

    logic [7:0] mem [0:65535];
    ev_t        rd_q[$];
    ev_t        wr_q[$];
    int         st_e[$];
    logic [7:0] st_p[$];

    oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_page  (src_page),
        .bus_addr  (bus_addr),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .cpu_block (cpu_block)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: read data appears the clock after the read strobe.
    always @(posedge clk) if (bus_read) bus_rdata <= mem[bus_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Per-clock invariants plus strobe capture; status follows the latest start.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_e = -1;
            foreach (st_e[j]) if (st_e[j] <= cyc) mon_e = st_e[j];
            check("rw_excl", 32'(bus_read & bus_write), 32'd0);
            check("busy", 32'(busy), 32'((mon_e >= 0) && (cyc < mon_e + XFER_CLKS)));
            check("cpu_block", 32'(cpu_block),
                  32'((mon_e >= 0) && (cyc >= mon_e + DMA_T_PER_BYTE) && (cyc < mon_e + XFER_CLKS)));
            if (bus_read) begin
                mon_ev.t = cyc; mon_ev.a = bus_addr; mon_ev.d = 8'h00;
                rd_q.push_back(mon_ev);
            end
            if (bus_write) begin
                mon_ev.t = cyc; mon_ev.a = bus_addr; mon_ev.d = bus_wdata;
                wr_q.push_back(mon_ev);
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    // Hold start for 'hold' clocks; each sampled clock is a (re)start.
    task automatic pulse(input logic [7:0] p, input int hold);
        @(negedge clk);
        #1;
        start    = 1'b1;
        src_page = p;
        for (int h = 0; h < hold; h++) begin
            st_e.push_back(cyc + 1);
            st_p.push_back(p);
            @(negedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    // Expected schedule: start E copies byte k with a read at E+4+4k and a write
    // two clocks later, unless a later start (or reset) arrives first.
    task automatic verify_episode(input string tag, input int hard_end);
        ev_t er[$];
        ev_t ew[$];
        ev_t ev;
        for (int j = 0; j < st_e.size(); j++) begin
            int         bound;
            logic [7:0] pg;
            bound = (j + 1 < st_e.size()) ? st_e[j + 1] : hard_end;
            pg    = (st_p[j] >= 8'hE0) ? st_p[j] - 8'h20 : st_p[j];
            for (int k = 0; k < DMA_OAM_LEN; k++) begin
                ev.t = st_e[j] + 4 + 4 * k;
                ev.a = {pg, 8'(k)};
                ev.d = 8'h00;
                if (ev.t < bound) er.push_back(ev);
                ev.t = ev.t + 2;
                ev.d = mem[{pg, 8'(k)}];
                ev.a = 16'hFE00 + 16'(k);
                if (ev.t < bound) ew.push_back(ev);
            end
        end
        check({tag, "/n_reads"}, rd_q.size(), er.size());
        check({tag, "/n_writes"}, wr_q.size(), ew.size());
        for (int k = 0; k < er.size() && k < rd_q.size(); k++) begin
            check($sformatf("%s/rd%0d_t", tag, k), rd_q[k].t, er[k].t);
            check($sformatf("%s/rd%0d_a", tag, k), rd_q[k].a, er[k].a);
        end
        for (int k = 0; k < ew.size() && k < wr_q.size(); k++) begin
            check($sformatf("%s/wr%0d_t", tag, k), wr_q[k].t, ew[k].t);
            check($sformatf("%s/wr%0d_a", tag, k), wr_q[k].a, ew[k].a);
            check($sformatf("%s/wr%0d_d", tag, k), wr_q[k].d, ew[k].d);
        end
        rd_q.delete();
        wr_q.delete();
        st_e.delete();
        st_p.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "/addr"}, bus_addr, 16'h0000);
        check({tag, "/wdata"}, bus_wdata, 8'h00);
        check({tag, "/read"}, bus_read, 1'b0);
        check({tag, "/write"}, bus_write, 1'b0);
        check({tag, "/busy"}, busy, 1'b0);
        check({tag, "/cpu_block"}, cpu_block, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e1;
        int n_hi;
        reset    = 1'b1;
        start    = 1'b0;
        src_page = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int k = 0; k < DMA_OAM_LEN; k++) mem[16'hC000 + 16'(k)] = 8'(k) ^ 8'h5A;
        #1;
        check_outputs_zero("reset_state");
        repeat (3) @(negedge clk);
        #1;
        reset  = 1'b0;
        mon_on = 1'b1;

        // Basic copy from page 0xC0.
        pulse(8'hC0, 1);
        e1 = cyc;
        wait_until(e1 + XFER_CLKS + 6);
        check("basic/n_writes_raw", wr_q.size(), 160);
        if (wr_q.size() == 160) begin
            check("basic/first_wr_t", wr_q[0].t, e1 + 6);
            check("basic/last_wr_t", wr_q[159].t, e1 + 642);
            check("basic/last_wr_a", wr_q[159].a, 16'hFE9F);
            check("basic/last_wr_d", wr_q[159].d, 8'd159 ^ 8'h5A);
        end
        verify_episode("basic", NO_BOUND);

        // Echo page mirrors into WRAM.
        pulse(8'hE1, 1);
        e1 = cyc;
        wait_until(e1 + XFER_CLKS + 6);
        n_hi = 0;
        foreach (rd_q[k]) if (rd_q[k].a >= 16'hE000) n_hi++;
        check("mirror/reads_above_e000", n_hi, 0);
        verify_episode("mirror", NO_BOUND);

        // Restart at +100 with a new page.
        pulse(8'hC0, 1);
        e1 = cyc;
        wait_until(e1 + 98);
        pulse(8'hD0, 1);
        check("restart/second_e", cyc, e1 + 100);
        wait_until(e1 + 100 + XFER_CLKS + 6);
        verify_episode("restart", NO_BOUND);

        // Asynchronous reset mid-transfer, between clock edges.
        pulse(8'hC3, 1);
        e1 = cyc;
        wait_until(e1 + 300);
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        verify_episode("reset_mid", e1 + 301);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        wait_until(cyc + 60);
        verify_episode("post_reset", NO_BOUND);

        // Random pages, held starts and random restart offsets.
        for (int it = 0; it < 4; it++) begin
            int off;
            off = $urandom_range(1, 720);
            pulse(8'($urandom), $urandom_range(1, 3));
            e1 = cyc;
            if (off < XFER_CLKS) begin
                wait_until(e1 + off);
                pulse(8'($urandom), $urandom_range(1, 2));
                e1 = cyc;
            end
            wait_until(e1 + XFER_CLKS + 6);
            verify_episode($sformatf("rand%0d", it), NO_BOUND);
        end

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Bus-initiator engine that performs the Game Boy OAM DMA transfer: on a write to the DMA register it copies 160 bytes from page `src_page`×0x100 to OAM at 0xFE00–0xFE9F. It sits beside the CPU as a second initiator on the memory bus. It drives the same request/response signalling the MMU responder answers, and it tells the CPU when its own bus access is blocked.

## Interface
Parameters:
- `OAM_BASE`, 16'hFE00: first destination address.
- `OAM_LEN`, 160: bytes per transfer.
- `T_PER_BYTE`, 4: clocks per byte, one M-cycle.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-clock pulse, decoded from a CPU write to 0xFF46.
- `src_page`  in  8  source page (data byte of that write), sampled when `start`=1.
- `bus_addr`  out  16  request address.
- `bus_read`  out  1  read strobe, one clock wide.
- `bus_write`  out  1  write strobe, one clock wide.
- `bus_wdata`  out  8  write data.
- `bus_rdata`  in  8  read data, valid the clock after `bus_read`.
- `busy`  out  1  transfer in progress, including the startup delay.
- `cpu_block`  out  1  CPU bus accesses outside 0xFF80–0xFFFE must be ignored while high.

## Operation
- States: IDLE, STARTUP, XFER.
- IDLE:
  - `start`=1 → latch the page and clear the index, then go to STARTUP.
- STARTUP:
  - Lasts `T_PER_BYTE` clocks with no bus strobes.
  - `busy`=1, `cpu_block`=0.
  - Then go to XFER.
- XFER: a phase counter `ph` runs 0..3 for each byte at index `i` (0..159).
  - ph0: `bus_read`=1, `bus_addr`={eff_page, i[7:0]}.
  - ph1: capture `bus_rdata` into the data register.
  - ph2: `bus_write`=1, `bus_addr`=`OAM_BASE`+i, `bus_wdata`=captured byte.
  - ph3: idle. If i=159, go to IDLE; otherwise i+1.
- Page mapping: eff_page = `src_page` for 0x00–0xDF. For 0xE0–0xFF, eff_page = `src_page` & 8'hDF (mirror into WRAM). There is no fault case.
- `cpu_block`=1 only in XFER.
- Width rules:
  - `i` is 8 bits.
  - `OAM_BASE`+i is a 16-bit add with no carry beyond 0xFE9F.
  - `ph` is 2 bits and wraps.
- Restart: `start` in STARTUP or XFER relatches `src_page`, sets i=0 and re-enters STARTUP. Any byte not yet written is dropped. A pending ph2 write in the same clock is suppressed.
- Reset, asynchronous at any time: state IDLE, i=0, ph=0, and every output 0 (`bus_addr`=0, `bus_wdata`=0, strobes 0, `busy`=0, `cpu_block`=0).

## Timing
- `start` is sampled at edge E. The FSM enters STARTUP at E.
- The first `bus_read` is at E+4. The first `bus_write` is at E+6.
- The last `bus_write` (i=159) is at E+4+159·4+2 = E+642.
- `busy` falls at E+644. Total occupancy is 644 clocks.
- `bus_read` and `bus_write` are never high in the same clock.
- Outputs are registered; no combinational path from inputs to outputs.
- `start` held high for several clocks counts as repeated restarts. The transfer completes 644 clocks after the last high clock.

## Structure
- Package `dma_pkg`:
  - `dma_state_t` enum {IDLE, STARTUP, XFER}.
  - Constants `DMA_OAM_BASE`, `DMA_OAM_LEN`, `DMA_T_PER_BYTE`, `DMA_REG_ADDR` (16'hFF46).
- A single module, no sub-module. Address decode of 0xFF46 stays in the MMU, which produces `start`.

## Test plan
- Basic copy: preload 0xC000–0xC09F with i^8'h5A, pulse `start` with page 0xC0. Required: 160 writes to 0xFE00+i with data i^8'h5A, the first at +6 clocks and the last at +642, and `busy` low at +644.
- Echo mirror: page 0xE1 must read 0xC100–0xC19F and no address ≥0xE000.
- Restart: pulse page 0xC0, then pulse page 0xD0 at +100. Required: bytes 0..23 come from 0xC0, then STARTUP, then the full 160 bytes from 0xD0. `busy` stays high throughout and falls 644 clocks after the second pulse.
- Reset mid-transfer: assert `reset` at +300. All outputs go 0 immediately with no clock edge; after release, no strobes until a new `start`.
- Handshake invariants: assert every clock that `bus_read` and `bus_write` are never both high, and that `cpu_block` is 0 in IDLE and STARTUP and 1 in XFER.
